// File: rtl/cpu_types_pkg.sv
// Core-wide width constants shared by the pipeline stages.
package cpu_types_pkg;
  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;
endpackage

// File: rtl/mem_pkg.sv
// Memory-stage types, FSM states and lane helpers derived from DATA_W.
package mem_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    MS_BYTE  = 2'b00,
    MS_HALF  = 2'b01,
    MS_WORD  = 2'b10,
    MS_DWORD = 2'b11
  } memsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  function automatic int laneCount(input int dataW);
    return dataW / 8;
  endfunction

  function automatic int offWidth(input int dataW);
    return (dataW == DWORD_W) ? 3 : 2;
  endfunction

  // A dword request on a 32-bit datapath degrades to a word.
  function automatic int sizeBytes(input memsize_t s, input int dataW);
    unique case (s)
      MS_BYTE:  return 1;
      MS_HALF:  return 2;
      MS_WORD:  return 4;
      default:  return (dataW == DWORD_W) ? 8 : 4;
    endcase
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Store lane replication, byte enables, load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   addr,
  input  logic [DATA_W-1:0]   storeData,
  input  logic [DATA_W-1:0]   loadData,
  input  memsize_t            size,
  input  logic                signedLoad,
  output logic [DATA_W-1:0]   alignedAddr,
  output logic [DATA_W-1:0]   storeRep,
  output logic [DATA_W-1:0]   loadExt,
  output logic [DATA_W/8-1:0] be,
  output logic                misaligned
);
  localparam int LANES = laneCount(DATA_W);
  localparam int OFF_W = offWidth(DATA_W);

  logic [OFF_W-1:0]         off;
  logic [DATA_W-1:0]        shifted;
  logic [DATA_W-1:0]        up;
  logic signed [DATA_W-1:0] ext;
  int                       nBytes;
  int                       sh;

  assign off = addr[OFF_W-1:0];

  always_comb begin
    nBytes      = sizeBytes(size, DATA_W);
    misaligned  = (int'(off) % nBytes) != 0;
    alignedAddr = {addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
    be          = LANES'(((1 << nBytes) - 1) << off);
    storeRep    = '0;
    for (int i = 0; i < LANES; i++)
      storeRep[i*8 +: 8] = storeData[(i % nBytes)*8 +: 8];
    // Move the lane to bit 0, then extend from its top bit.
    shifted = loadData >> {off, 3'b000};
    sh      = DATA_W - nBytes * 8;
    up      = shifted << sh;
    ext     = $signed(up) >>> sh;
    loadExt = signedLoad ? ext : (up >> sh);
  end
endmodule

// File: rtl/mem_stage_sized.sv
// MEM stage: dcache request/hold FSM and MEM/WB latch.
// Optional LL/SC link register under `MEM_LLSC_EN.
module mem_stage_sized
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SEL_W  = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   nPC,
  input  logic                regWr,
  input  logic [SEL_W-1:0]    regSel,
  input  logic [REG_W-1:0]    regDst,
  input  logic [DATA_W-1:0]   ALUOut,
  input  logic [DATA_W-1:0]   rtdat,
  input  logic                dREN,
  input  logic                dWEN,
  input  logic [1:0]          memsize,
  input  logic                memsigned,
  input  logic                flush,
  input  logic                ihit,
  input  logic                dhit,
  input  logic [DATA_W-1:0]   dmemload,
`ifdef MEM_LLSC_EN
  input  logic                ll,
  input  logic                sc,
`endif
  output logic                dmemREN,
  output logic                dmemWEN,
  output logic [DATA_W-1:0]   dmemaddr,
  output logic [DATA_W-1:0]   dmemstore,
  output logic [DATA_W/8-1:0] dmembe,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   nPC_next,
  output logic                regWr_next,
  output logic [SEL_W-1:0]    regSel_next,
  output logic [REG_W-1:0]    regDst_next,
  output logic [DATA_W-1:0]   ALUOut_next,
  output logic [DATA_W-1:0]   dmemload_next,
  output logic                wb_valid,
  output logic                misalign_err
);
  localparam int LANES = laneCount(DATA_W);

  mem_state_t        state, nextState;
  logic [DATA_W-1:0] alignedAddr, storeRep, loadExt;
  logic [DATA_W-1:0] result, capReg, wbData;
  logic [LANES-1:0]  be;
  logic              misaligned, memOp, access, req, retire, scFail;

  mem_lane_align #(.DATA_W(DATA_W)) uAlign (
    .addr       (ALUOut),
    .storeData  (rtdat),
    .loadData   (dmemload),
    .size       (memsize_t'(memsize)),
    .signedLoad (memsigned),
    .alignedAddr(alignedAddr),
    .storeRep   (storeRep),
    .loadExt    (loadExt),
    .be         (be),
    .misaligned (misaligned)
  );

  assign memOp     = ex_valid & (dREN | dWEN);
  assign access    = memOp & ~misaligned & ~scFail;
  assign req       = ~RST & ((state == WAIT) | ((state == IDLE) & access));
  assign dmemREN   = req & dREN;
  assign dmemWEN   = req & dWEN;
  assign mem_stall = ~RST & access & ~dhit & (state != DONE);
  assign retire    = ihit & ~mem_stall;
  assign dmemaddr  = RST ? '0 : alignedAddr;
  assign dmemstore = RST ? '0 : storeRep;
  assign dmembe    = RST ? '0 : be;
  assign wbData    = (state == DONE) ? capReg : result;

`ifdef MEM_LLSC_EN
  logic              linkValid, scOp, scOk;
  logic [DATA_W-1:0] linkAddr;

  assign scOp   = sc & dWEN;
  assign scOk   = linkValid & (linkAddr == alignedAddr);
  assign scFail = scOp & ~scOk;
  assign result = scOp ? DATA_W'(scOk) : loadExt;

  // Later assignments win: an LL retiring sets the link last.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      linkValid <= 1'b0;
      linkAddr  <= '0;
    end else begin
      if (req & dhit & dWEN & (linkAddr == alignedAddr))
        linkValid <= 1'b0;
      if (retire & ex_valid & scOp)
        linkValid <= 1'b0;
      if (retire & ex_valid & ~flush & ll & dREN & ~misaligned) begin
        linkValid <= 1'b1;
        linkAddr  <= alignedAddr;
      end
    end
  end
`else
  assign scFail = 1'b0;
  assign result = loadExt;
`endif

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (access)
              nextState = dhit ? (ihit ? IDLE : DONE) : WAIT;
      WAIT: if (dhit)
              nextState = ihit ? IDLE : DONE;
      DONE: if (ihit)
              nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             capReg <= '0;
    else if (req & dhit) capReg <= result;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nPC_next      <= '0;
      regWr_next    <= 1'b0;
      regSel_next   <= '0;
      regDst_next   <= '0;
      ALUOut_next   <= '0;
      dmemload_next <= '0;
      wb_valid      <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (retire) begin
        misalign_err <= memOp & misaligned & ~flush;
        if (flush | ~ex_valid) begin
          wb_valid   <= 1'b0;
          regWr_next <= 1'b0;
        end else begin
          wb_valid      <= 1'b1;
          regWr_next    <= regWr & ~(memOp & misaligned);
          nPC_next      <= nPC;
          regSel_next   <= regSel;
          regDst_next   <= regDst;
          ALUOut_next   <= ALUOut;
          dmemload_next <= wbData;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_sized.sv
// Randomized scoreboard bench for mem_stage_sized at DATA_W=32.
module tb_mem_stage_sized;
  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, regWr, dREN, dWEN, memsigned;
  logic        flush, ihit, dhit;
  logic [31:0] nPC, ALUOut, rtdat, dmemload;
  logic [2:0]  regSel;
  logic [4:0]  regDst;
  logic [1:0]  memsize;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic [3:0]  dmembe;
  logic [31:0] nPC_next, ALUOut_next, dmemload_next;
  logic        regWr_next, wb_valid, misalign_err;
  logic [2:0]  regSel_next;
  logic [4:0]  regDst_next;
`ifdef MEM_LLSC_EN
  logic        ll, sc;
  bit          llG, scG, linkV;
  logic [31:0] linkA;
`endif

  always #5 CLK = ~CLK;

  mem_stage_sized dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .nPC(nPC),
    .regWr(regWr), .regSel(regSel), .regDst(regDst),
    .ALUOut(ALUOut), .rtdat(rtdat), .dREN(dREN), .dWEN(dWEN),
    .memsize(memsize), .memsigned(memsigned), .flush(flush),
    .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
`ifdef MEM_LLSC_EN
    .ll(ll), .sc(sc),
`endif
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmembe(dmembe), .mem_stall(mem_stall),
    .nPC_next(nPC_next), .regWr_next(regWr_next),
    .regSel_next(regSel_next), .regDst_next(regDst_next),
    .ALUOut_next(ALUOut_next), .dmemload_next(dmemload_next),
    .wb_valid(wb_valid), .misalign_err(misalign_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wbValid;
    bit          regWr;
    logic [2:0]  sel;
    logic [4:0]  dst;
    logic [31:0] npc;
    logic [31:0] alu;
    bit          chkLoad;
    logic [31:0] load;
    bit          mis;
  } exp_t;

  exp_t sbq[$];

  // Monitor: one MEM/WB entry is due after every edge the stage advanced on.
  initial begin
    bit   pend;
    bit   expMis;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) pend = 1'b0;
      else begin
        expMis = 1'b0;
        if (pend) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: actual empty required entry");
          end else begin
            e = sbq.pop_front();
            chk("wb_valid", wb_valid, e.wbValid);
            chk("regWr_next", regWr_next, e.regWr);
            if (e.wbValid) begin
              chk("regSel_next", regSel_next, e.sel);
              chk("regDst_next", regDst_next, e.dst);
              chk("nPC_next", nPC_next, e.npc);
              chk("ALUOut_next", ALUOut_next, e.alu);
            end
            if (e.chkLoad) chk("dmemload_next", dmemload_next, e.load);
            expMis = e.mis;
          end
        end
        chk("misalign_err", misalign_err, expMis);
        pend = ihit && !mem_stall;
      end
    end
  end

  // One instruction from EX/MEM until it retires into MEM/WB.
  task automatic runOp(input bit v, input bit rd, input bit wr,
                       input logic [1:0] sz, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] load, input int lat,
                       input int hold, input int flushPct);
    int          n, c;
    bit          mis, acc, hitDone, done, ihitV, dhitV, flushV;
    bit          expStall, expReq, retireNow, storeHit, retFlush;
    bit          isSc, scOkM;
    logic [31:0] mask, expLoad, expStore;
    logic [3:0]  expBe;
    exp_t        e;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = v && (rd || wr) && (addr % n != 0);
    acc = v && (rd || wr) && !mis;
    isSc  = 1'b0;
    scOkM = 1'b0;
`ifdef MEM_LLSC_EN
    isSc  = scG && wr;
    scOkM = linkV && (linkA == (addr & ~32'h3));
    if (isSc && !scOkM) acc = 1'b0;
    ll = llG;
    sc = scG;
`endif
    mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    expLoad = (load >> (8 * (addr % 4))) & mask;
    if (sgn && n < 4 && expLoad[8*n-1]) expLoad = expLoad | ~mask;
    if (isSc) expLoad = {31'd0, scOkM};
    expStore = (n == 1) ? {4{data[7:0]}} :
               (n == 2) ? {2{data[15:0]}} : data;
    expBe    = 4'(((1 << n) - 1) << (addr % 4));
    ex_valid = v;   nPC = $urandom; regWr = 1'($urandom);
    regSel = 3'($urandom); regDst = 5'($urandom);
    ALUOut = addr; rtdat = data; dREN = rd; dWEN = wr;
    memsize = sz; memsigned = sgn;
    hitDone = 1'b0; done = 1'b0; storeHit = 1'b0; retFlush = 1'b0;
    c = 0;
    while (!done) begin
      if (c > 60) begin
        checks++;
        errors++;
        $display("FAIL op_timeout: actual %0d cycles required retire", c);
        break;
      end
      dhitV = acc && !hitDone && (c == lat);
      if (hitDone) begin
        if (hold > 1) begin ihitV = 1'b0; hold--; end
        else ihitV = 1'b1;
      end else if (dhitV) ihitV = (hold == 0);
      else ihitV = ($urandom % 3) != 0;
      flushV   = ($urandom % 100) < flushPct;
      ihit = ihitV; dhit = dhitV; flush = flushV;
      dmemload = dhitV ? load : $urandom;
      expReq    = acc && !hitDone;
      expStall  = expReq && !dhitV;
      retireNow = ihitV && !expStall;
      if (retireNow) begin
        e.wbValid = v && !flushV;
        e.regWr   = e.wbValid && regWr && !mis;
        e.sel = regSel; e.dst = regDst; e.npc = nPC; e.alu = addr;
        e.chkLoad = e.wbValid && (isSc || (acc && rd));
        e.load    = expLoad;
        e.mis     = e.wbValid && mis;
        sbq.push_back(e);
        retFlush = flushV;
      end
      @(negedge CLK);
      chk("dmemREN", dmemREN, expReq && rd);
      chk("dmemWEN", dmemWEN, expReq && wr);
      chk("mem_stall", mem_stall, expStall);
      if (acc && c == 0) begin
        chk("dmemaddr", dmemaddr, addr & ~32'h3);
        chk("dmembe", dmembe, expBe);
        if (wr) chk("dmemstore", dmemstore, expStore);
      end
      @(posedge CLK); #1;
      if (dhitV) begin hitDone = 1'b1; storeHit = wr; end
      if (retireNow) done = 1'b1;
      c++;
    end
`ifdef MEM_LLSC_EN
    if (storeHit && linkA == (addr & ~32'h3)) linkV = 1'b0;
    if (v && isSc) linkV = 1'b0;
    if (v && !retFlush && llG && rd && !mis) begin
      linkV = 1'b1;
      linkA = addr & ~32'h3;
    end
`else
    if (storeHit && retFlush) ; // keep both flags referenced
`endif
  endtask

  initial begin
    int          n, off, k, sz;
    logic [31:0] a;
`ifdef MEM_LLSC_EN
    ll = 0; sc = 0; llG = 0; scG = 0; linkV = 0; linkA = '0;
`endif
    RST = 1'b1; ex_valid = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    ALUOut = 32'h100; nPC = 32'h4; regWr = 1'b1; regSel = 3'd1;
    regDst = 5'd3; rtdat = 32'h5; memsize = 2'd2; memsigned = 1'b0;
    flush = 1'b0; ihit = 1'b1; dhit = 1'b0; dmemload = 32'h1;
    @(negedge CLK);
    chk("rst_dmemREN", dmemREN, 0);
    chk("rst_mem_stall", mem_stall, 0);
    chk("rst_dmemaddr", dmemaddr, 0);
    chk("rst_dmembe", dmembe, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_regWr_next", regWr_next, 0);
    chk("rst_dmemload_next", dmemload_next, 0);
    chk("rst_nPC_next", nPC_next, 0);
    @(posedge CLK); #1;
    ex_valid = 1'b0; dREN = 1'b0; ihit = 1'b0;
    RST = 1'b0;

    runOp(1, 0, 1, 2'd0, 0, 32'h103, 32'h0000_00AB, 32'h0, 1, 0, 0);
    runOp(1, 1, 0, 2'd1, 1, 32'h202, 32'h0, 32'h8001_1234, 3, 0, 0);
    runOp(1, 1, 0, 2'd2, 0, 32'h404, 32'h0, 32'hCAFE_F00D, 1, 2, 0);
    runOp(1, 1, 0, 2'd2, 0, 32'h006, 32'h0, 32'h1234_5678, 0, 0, 0);
    runOp(1, 0, 1, 2'd2, 0, 32'h508, 32'h1357_9BDF, 32'h0, 2, 0, 100);
    runOp(1, 1, 0, 2'd0, 0, 32'h601, 32'h0, 32'h0000_F100, 0, 0, 0);

    // Reset in the middle of a wait drops the request at once.
    ex_valid = 1'b1; dREN = 1'b1; dWEN = 1'b0; memsize = 2'd2;
    ALUOut = 32'h300; ihit = 1'b1; dhit = 1'b0; flush = 1'b0;
    @(negedge CLK);
    chk("pre_rst_dmemREN", dmemREN, 1);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_dmemREN", dmemREN, 0);
    chk("mid_rst_mem_stall", mem_stall, 0);
    @(posedge CLK); #1;
    ex_valid = 1'b0; dREN = 1'b0; ihit = 1'b0;
    RST = 1'b0;

`ifdef MEM_LLSC_EN
    llG = 1; runOp(1, 1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h77, 1, 0, 0);
    llG = 0; runOp(1, 0, 1, 2'd2, 0, 32'h40, 32'h99, 32'h0, 1, 0, 0);
    scG = 1; runOp(1, 0, 1, 2'd2, 0, 32'h40, 32'h55, 32'h0, 1, 0, 0);
    scG = 0;
    llG = 1; runOp(1, 1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h77, 1, 0, 0);
    llG = 0;
    scG = 1; runOp(1, 0, 1, 2'd2, 0, 32'h40, 32'h66, 32'h0, 2, 1, 0);
    scG = 0;
`endif

    for (int i = 0; i < 300; i++) begin
      sz = $urandom % 4;
      n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      if ($urandom % 4 == 0) off = $urandom % 4;
      else off = n * ($urandom % (4 / n));
      a = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      k = $urandom % 3;
      runOp(($urandom % 8) != 0, k == 1, k == 2, 2'(sz), 1'($urandom),
            a, $urandom, $urandom, $urandom % 4, $urandom % 3, 10);
    end

    ihit = 1'b0; ex_valid = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    flush = 1'b0; dhit = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
